// File: rtl/instr_fetch.sv
// Instruction fetch: holds the PC, fetches words over a single-outstanding imem handshake and
// hands them to decode. Optional MISALIGN_TRAP_EN traps on misaligned redirect targets.
`timescale 1ns/1ps

// state | meaning
// FETCH | issue request for pc
// WAIT  | request outstanding, counting towards timeout
// HOLD  | word presented to decode, waiting for ins_ready
// ERR   | sticky error, only rst leaves
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        pc_sel,
  input  logic [31:0] br_target,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, ERR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic        handshake;
  logic        trap;
  logic [31:0] next_pc;

  assign handshake = (state == HOLD) && ins_ready;
  assign next_pc   = pc_sel ? (br_target & 32'hFFFF_FFFC) : pc + 32'd4;

`ifdef MISALIGN_TRAP_EN
  assign trap = handshake && pc_sel && (br_target[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Request is combinational so a consumed word can launch the next fetch in the same cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (rst) begin
      imem_addr = RESET_PC;
    end else begin
      case (state)
        FETCH: imem_req = 1'b1;
        HOLD: begin
          if (handshake && !trap) begin
            imem_req  = 1'b1;
            imem_addr = next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ins       <= 32'h0;
      ins_pc    <= 32'h0;
      ins_valid <= 1'b0;
      fetch_err <= 1'b0;
      fetch_cnt <= 32'h0;
      wait_cnt  <= 8'h0;
    end else begin
      case (state)
        FETCH: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            ins       <= imem_rdata;
            ins_pc    <= pc;
            ins_valid <= 1'b1;
            wait_cnt  <= 8'h0;
            state     <= HOLD;
          end else if (wait_cnt == TIMEOUT_CNT - 8'd1) begin
            fetch_err <= 1'b1;
            wait_cnt  <= 8'h0;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            ins_valid <= 1'b0;
            if (trap) begin
              // keep the raw target so the faulting address is visible
              fetch_err <= 1'b1;
              pc        <= br_target;
              state     <= ERR;
            end else begin
              pc    <= next_pc;
              state <= WAIT;
            end
          end
        end
        ERR: begin
          ins_valid <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule
